// File: rtl/wb_rr_arb_pkg.sv
// Shared widths and FSM state type for the Wishbone round-robin arbiter.
package wb_arb_pkg;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = 4;
    localparam int TO_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;
endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int NM = 4
) (
    input  logic [NM-1:0]         req,
    input  logic [$clog2(NM)-1:0] last,
    output logic [NM-1:0]         win
);
    localparam int LW = $clog2(NM);

    logic [LW-1:0] idx;

    // Scan farthest-first so the nearest requester after 'last' overwrites.
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = NM; k >= 1; k--) begin
            idx = LW'((int'(last) + k) % NM);
            if (req[idx]) begin
                win      = '0;
                win[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/wb_rr_arb.sv
// Round-robin Wishbone arbiter: NM masters share one slave, grant held while m_cyc is high.
// Optional slave-stall timeout enabled with `define WB_ARB_TIMEOUT_EN.
module wb_rr_arb
    import wb_arb_pkg::*;
#(
    parameter int NM     = 4,
    parameter int TO_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NM*AW-1:0]  m_adr,
    input  logic [NM*DW-1:0]  m_din,
    output logic [DW-1:0]     m_dout,
    input  logic [NM-1:0]     m_cyc,
    input  logic [NM-1:0]     m_stb,
    input  logic [NM-1:0]     m_we,
    input  logic [NM*SW-1:0]  m_sel,
    output logic [NM-1:0]     m_ack,
    output logic [NM-1:0]     m_err,
    output logic [NM-1:0]     m_rty,
    output logic [AW-1:0]     s_adr,
    output logic [DW-1:0]     s_dout,
    output logic [SW-1:0]     s_sel,
    output logic              s_cyc,
    output logic              s_stb,
    output logic              s_we,
    input  logic [DW-1:0]     s_din,
    input  logic              s_ack,
    input  logic              s_err,
    input  logic              s_rty,
    output logic [NM-1:0]     gnt
);
    localparam int LW = $clog2(NM);

    arb_state_e    state, state_nx;
    logic [NM-1:0] gnt_q, win;
    logic [LW-1:0] last, gidx, win_idx;
    logic          own, to_hit;

    wb_rr_pick #(.NM(NM)) u_pick (
        .req  (m_cyc),
        .last (last),
        .win  (win)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NM; i++)
            if (win[i]) win_idx = LW'(i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt_q <= '0;
            last  <= LW'(NM - 1);
            gidx  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx == OWN) begin
                gnt_q <= win;
                last  <= win_idx;
                gidx  <= win_idx;
            end else if (state_nx == IDLE) begin
                gnt_q <= '0;
            end
        end
    end

    // Outputs are gated by rst so they sit at idle values for the whole reset.
    assign own    = (state == OWN) && !rst;
    assign gnt    = rst ? '0 : gnt_q;
    assign m_dout = s_din;

    always_comb begin
        state_nx = state;
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_sel    = '0;
        s_adr    = '0;
        s_dout   = '0;
        m_ack    = '0;
        m_err    = '0;
        m_rty    = '0;
        case (state)
            IDLE:    if (|m_cyc) state_nx = OWN;
            OWN:     if (!m_cyc[gidx]) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (own) begin
            s_cyc       = m_cyc[gidx];
            s_stb       = m_stb[gidx] && !to_hit;
            s_we        = m_we[gidx];
            s_sel       = m_sel[gidx*SW +: SW];
            s_adr       = m_adr[gidx*AW +: AW];
            s_dout      = m_din[gidx*DW +: DW];
            m_ack[gidx] = s_ack && s_stb;
            m_err[gidx] = (s_err && s_stb) || to_hit;
            m_rty[gidx] = s_rty && s_stb;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    assign to_hit = own && m_stb[gidx] && (to_cnt == TO_W'(TO_CYC));

    // Counts stalled strobe cycles; any termination or loss of ownership restarts it.
    always_ff @(posedge clk) begin
        if (rst || state != OWN || to_hit || s_ack || s_err || s_rty)
            to_cnt <= '0;
        else if (s_stb)
            to_cnt <= to_cnt + 1'b1;
    end
`else
    logic [31:0] unused_to_cyc;
    assign unused_to_cyc = TO_CYC;
    assign to_hit        = 1'b0;
`endif
endmodule

// File: tb/tb_wb_rr_arb.sv
// Self-checking bench for wb_rr_arb: directed scenarios plus random traffic against a cycle model.
module tb_wb_rr_arb;
    localparam int NM = 4;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NM*32-1:0]  m_adr, m_din;
    logic [31:0]       m_dout;
    logic [NM-1:0]     m_cyc, m_stb, m_we;
    logic [NM*4-1:0]   m_sel;
    logic [NM-1:0]     m_ack, m_err, m_rty;
    logic [31:0]       s_adr, s_dout, s_din;
    logic [3:0]        s_sel;
    logic              s_cyc, s_stb, s_we;
    logic              s_ack, s_err, s_rty;
    logic [NM-1:0]     gnt;

    wb_rr_arb #(.NM(NM), .TO_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .m_adr(m_adr), .m_din(m_din), .m_dout(m_dout),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel),
        .m_ack(m_ack), .m_err(m_err), .m_rty(m_rty),
        .s_adr(s_adr), .s_dout(s_dout), .s_sel(s_sel),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
        .s_din(s_din), .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty),
        .gnt(gnt)
    );

    always #5 clk = ~clk;

    int            n_run = 0, n_fail = 0;
    int            mown = -1, mlast = NM - 1, mcnt = 0;
    logic [NM-1:0] e_ack = '0;
    logic [NM-1:0] prev_gnt = '0;
    int            gnt_order[$];
    int            ack2_seen = 0, err_seen = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // One cycle: compare outputs to the model for the current inputs, advance the model, wait.
    task automatic step();
        bit            own, hit, stb;
        logic [NM-1:0] oh, e_err, e_rty;
        #1;
        own = !rst && (mown >= 0);
        hit = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
        hit = own && m_stb[mown] && (mcnt == TO);
`endif
        stb = own && m_stb[mown] && !hit;
        oh  = '0;
        if (own) oh[mown] = 1'b1;
        e_ack = (s_ack && stb) ? oh : '0;
        e_err = ((s_err && stb) || hit) ? oh : '0;
        e_rty = (s_rty && stb) ? oh : '0;

        chk("gnt",    gnt,    oh);
        chk("s_cyc",  s_cyc,  own && m_cyc[mown]);
        chk("s_stb",  s_stb,  stb);
        chk("s_we",   s_we,   own && m_we[mown]);
        chk("s_adr",  s_adr,  own ? m_adr[mown*32 +: 32] : 32'h0);
        chk("s_dout", s_dout, own ? m_din[mown*32 +: 32] : 32'h0);
        chk("s_sel",  s_sel,  own ? m_sel[mown*4 +: 4] : 4'h0);
        chk("m_ack",  m_ack,  e_ack);
        chk("m_err",  m_err,  e_err);
        chk("m_rty",  m_rty,  e_rty);
        chk("m_dout", m_dout, s_din);

        if (m_ack[2]) ack2_seen++;
        if (|m_err) err_seen++;
        if (gnt != '0 && gnt != prev_gnt)
            for (int i = 0; i < NM; i++) if (gnt[i]) gnt_order.push_back(i);
        prev_gnt = gnt;

        if (rst) begin
            mown = -1; mlast = NM - 1; mcnt = 0;
        end else if (mown < 0) begin
            for (int k = 1; k <= NM; k++)
                if (m_cyc[(mlast + k) % NM]) begin
                    mown = (mlast + k) % NM;
                    break;
                end
            if (mown >= 0) mlast = mown;
            mcnt = 0;
        end else begin
            if (hit || s_ack || s_err || s_rty) mcnt = 0;
            else if (stb) mcnt++;
            if (!m_cyc[mown]) begin mown = -1; mcnt = 0; end
        end
        @(negedge clk);
    endtask

    initial begin
        int  a0, e0, wait_n, r;
        bit  stall;
        rst = 1'b1;
        m_adr = '0; m_din = '0; m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0;
        s_din = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        @(negedge clk);
        step(); step();
        rst = 1'b0;

        // All four request together; each drops cyc after its ack.
        for (int i = 0; i < NM; i++) begin
            m_adr[i*32 +: 32] = 32'h1000 * (i + 1);
            m_din[i*32 +: 32] = $urandom;
            m_sel[i*4 +: 4]   = 4'hF;
        end
        m_cyc = '1; m_stb = '1; s_ack = 1'b1;
        gnt_order.delete();
        for (int c = 0; c < 16; c++) begin
            step();
            m_cyc &= ~e_ack; m_stb &= ~e_ack;
        end
        chk("rr_count", gnt_order.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < gnt_order.size()) chk($sformatf("rr_order%0d", i), gnt_order[i], i);

        // Master 2 single write to a zero-delay slave.
        a0 = ack2_seen;
        m_din[95:64] = 32'hDEAD_BEEF; m_sel[11:8] = 4'b0011; m_we = 4'b0100;
        m_cyc = 4'b0100; m_stb = 4'b0100;
        for (int c = 0; c < 6; c++) begin
            step();
            m_cyc &= ~e_ack; m_stb &= ~e_ack;
        end
        chk("m2_ack_pulses", ack2_seen - a0, 1);

        // Master 1 holds a 4-beat read while master 0 waits.
        m_we = '0; m_cyc = 4'b0010; m_stb = 4'b0010;
        step(); step();
        m_cyc = 4'b0011; m_stb = 4'b0011;
        for (int c = 0; c < 4; c++) step();
        m_cyc = 4'b0001; m_stb = 4'b0001;
        wait_n = 0;
        while (gnt !== 4'b0001 && wait_n < 10) begin
            step();
            wait_n++;
        end
        chk("m0_latency", wait_n, 2);

        // Reset while master 3 owns a stalled slave.
        m_cyc = '0; m_stb = '0; s_ack = 1'b0;
        step(); step();
        m_cyc = 4'b1000; m_stb = 4'b1000;
        for (int c = 0; c < 3; c++) step();
        chk("pre_rst_gnt", gnt, 4'b1000);
        rst = 1'b1; m_cyc = 4'b1001; m_stb = 4'b1001;
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_scyc", s_cyc, 1'b0);
        chk("post_rst_gnt", gnt, 4'b0000);
        step();
        chk("post_rst_win", gnt, 4'b0001);

        // Slave never terminates.
        m_cyc = '0; m_stb = '0;
        step(); step();
        e0 = err_seen;
        m_cyc = 4'b0010; m_stb = 4'b0010;
        for (int c = 0; c < 14; c++) step();
`ifdef WB_ARB_TIMEOUT_EN
        chk("timeout_err", err_seen - e0, 1);
`else
        chk("timeout_err", err_seen - e0, 0);
`endif
        m_cyc = '0; m_stb = '0;
        step();

        // Random traffic with slave stall phases and occasional reset.
        stall = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NM; i++) begin
                if (m_cyc[i]) begin
                    if (e_ack[i] ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 15) == 0))
                        m_cyc[i] = 1'b0;
                end else begin
                    m_cyc[i] = ($urandom_range(0, 3) == 0);
                end
                m_stb[i]          = m_cyc[i] && ($urandom_range(0, 3) != 0);
                m_we[i]           = $urandom_range(0, 1);
                m_sel[i*4 +: 4]   = 4'($urandom);
                m_adr[i*32 +: 32] = $urandom;
                m_din[i*32 +: 32] = $urandom;
            end
            if ($urandom_range(0, 63) == 0) stall = !stall;
            r     = $urandom_range(0, 9);
            s_ack = !stall && (r < 5);
            s_err = !stall && (r == 5);
            s_rty = !stall && (r == 6);
            s_din = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
